// File: rtl/pc_seq_ctrl_pkg.sv
// Shared NPC encodings and PC-sequencer state type.
// Used by pc_seq_ctrl and its NPC sub-module.
package pc_seq_ctrl_pkg;

  localparam logic [4:0] NPC_PLUS4  = 5'b00000;
  localparam logic [4:0] NPC_BRANCH = 5'b00001;
  localparam logic [4:0] NPC_JUMP   = 5'b00010;
  localparam logic [4:0] NPC_JALR   = 5'b00100;

  typedef enum logic [1:0] {
    PCS_BOOT  = 2'd0,
    PCS_RUN   = 2'd1,
    PCS_FLUSH = 2'd2
  } pcs_e;

  // JALR wins over JAL, JAL over a taken branch.
  function automatic logic [4:0] npc_sel(
    input logic jalr,
    input logic jal,
    input logic br_tk
  );
    logic [4:0] op;
    op = NPC_PLUS4;
    if (jalr)       op = NPC_JALR;
    else if (jal)   op = NPC_JUMP;
    else if (br_tk) op = NPC_BRANCH;
    return op;
  endfunction

endpackage

// File: rtl/pc_seq_ctrl_npc.sv
// Next-PC datapath: sequential, PC-relative or register target.
// Selected by the NPCOp code from pc_seq_ctrl_pkg.
module pc_seq_ctrl_npc
  import pc_seq_ctrl_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] alu_out_i,
  input  logic [4:0]  npc_op_i,
  output logic [31:0] npc_o
);

  always_comb begin
    npc_o = pc_i + 32'd4;
    case (npc_op_i)
      NPC_BRANCH,
      NPC_JUMP:   npc_o = ex_pc_i + imm_i;
      NPC_JALR:   npc_o = alu_out_i;
      default:    npc_o = pc_i + 32'd4;
    endcase
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch PC owner: redirect sequencing, flush pulses, fetch-valid.
// Optional PC_MISALIGN_TRAP_EN traps misaligned redirect targets.
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          CNT_W        = 16,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             stall,
  input  logic             if_ready,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_taken,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      alu_out,
  output logic [31:0]      pc,
  output logic             pc_valid,
  output logic [4:0]       npc_op,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic             trap,
  output logic [31:0]      trap_epc
);

  localparam logic [1:0] FL_INIT = FLUSH_CYCLES[1:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pcs_e             state_q;
  logic [1:0]       fl_cnt_q;
  logic [31:0]      pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             redir;
  logic             mis;
  logic [31:0]      npc;
  logic [31:0]      tgt;
  logic [31:0]      pc_d;

  assign redir = (state_q == PCS_RUN) & ex_valid &
                 (ex_jalr | ex_jal | (ex_branch & ex_taken));

  assign npc_op = redir ? npc_sel(ex_jalr, ex_jal, ex_branch & ex_taken)
                        : NPC_PLUS4;

  pc_seq_ctrl_npc u_npc (
    .pc_i      (pc_q),
    .ex_pc_i   (ex_pc),
    .imm_i     (ex_imm),
    .alu_out_i (alu_out),
    .npc_op_i  (npc_op),
    .npc_o     (npc)
  );

  assign tgt = (npc_op == NPC_JALR) ? {npc[31:1], 1'b0} : npc;

`ifdef PC_MISALIGN_TRAP_EN
  assign mis = redir & (tgt[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  assign pc_d  = mis ? TRAP_VEC : tgt;
  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= PCS_BOOT;
      fl_cnt_q <= 2'd0;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        PCS_BOOT: state_q <= PCS_RUN;
        PCS_RUN: begin
          if (redir) begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            if (FLUSH_CYCLES != 0) begin
              state_q  <= PCS_FLUSH;
              fl_cnt_q <= FL_INIT;
            end
          end else if (!stall && if_ready) begin
            pc_q <= npc;
          end
        end
        PCS_FLUSH: begin
          fl_cnt_q <= fl_cnt_q - 2'd1;
          if (fl_cnt_q <= 2'd1) state_q <= PCS_RUN;
        end
        default: state_q <= PCS_BOOT;
      endcase
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic        trap_q;
  logic [31:0] epc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      trap_q <= 1'b0;
      epc_q  <= 32'd0;
    end else begin
      trap_q <= mis;
      if (mis) epc_q <= ex_pc;
    end
  end

  assign trap     = trap_q;
  assign trap_epc = epc_q;
`else
  assign trap     = 1'b0;
  assign trap_epc = 32'd0;
`endif

  assign pc           = pc_q;
  assign pc_valid     = (state_q == PCS_RUN);
  assign if_id_flush  = redir;
  assign id_ex_flush  = redir;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Randomized self-checking bench for pc_seq_ctrl against a cycle model.
// Honors PC_MISALIGN_TRAP_EN the same way as the design.
module tb_pc_seq_ctrl;
  import pc_seq_ctrl_pkg::*;

  localparam int          FC  = 1;
  localparam int          CW  = 4;
  localparam logic [31:0] RP  = 32'h0000_0000;
  localparam logic [31:0] TV  = 32'h0000_0100;

  logic          clk;
  logic          rstn;
  logic          stall;
  logic          if_ready;
  logic          ex_valid;
  logic          ex_branch;
  logic          ex_taken;
  logic          ex_jal;
  logic          ex_jalr;
  logic [31:0]   ex_pc;
  logic [31:0]   ex_imm;
  logic [31:0]   alu_out;
  logic [31:0]   pc;
  logic          pc_valid;
  logic [4:0]    npc_op;
  logic          if_id_flush;
  logic          id_ex_flush;
  logic [CW-1:0] redirect_cnt;
  logic          trap;
  logic [31:0]   trap_epc;

  pc_seq_ctrl #(
    .RESET_PC     (RP),
    .FLUSH_CYCLES (FC),
    .CNT_W        (CW),
    .TRAP_VEC     (TV)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .stall        (stall),
    .if_ready     (if_ready),
    .ex_valid     (ex_valid),
    .ex_branch    (ex_branch),
    .ex_taken     (ex_taken),
    .ex_jal       (ex_jal),
    .ex_jalr      (ex_jalr),
    .ex_pc        (ex_pc),
    .ex_imm       (ex_imm),
    .alu_out      (alu_out),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .npc_op       (npc_op),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .redirect_cnt (redirect_cnt),
    .trap         (trap),
    .trap_epc     (trap_epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit          m_boot;
  int          m_bub;
  logic [31:0] m_pc;
  int          m_cnt;
  bit          m_trap;
  logic [31:0] m_epc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_run();
    return !m_boot && (m_bub == 0);
  endfunction

  function automatic bit m_redir();
    return m_run() && ex_valid &&
           (ex_jalr || ex_jal || (ex_branch && ex_taken));
  endfunction

  function automatic logic [4:0] m_op();
    if (!m_redir())             return NPC_PLUS4;
    if (ex_jalr)                return NPC_JALR;
    if (ex_jal)                 return NPC_JUMP;
    return NPC_BRANCH;
  endfunction

  function automatic logic [31:0] m_tgt();
    if (ex_jalr) return alu_out & 32'hFFFF_FFFE;
    return ex_pc + ex_imm;
  endfunction

  task automatic idle();
    stall     = 1'b0;
    if_ready  = 1'b1;
    ex_valid  = 1'b0;
    ex_branch = 1'b0;
    ex_taken  = 1'b0;
    ex_jal    = 1'b0;
    ex_jalr   = 1'b0;
    ex_pc     = 32'd0;
    ex_imm    = 32'd0;
    alu_out   = 32'd0;
  endtask

  task automatic check_regs();
    chk("pc", pc, m_pc);
    chk("pc_valid", {31'd0, pc_valid}, {31'd0, m_run()});
    chk("redirect_cnt", {{(32-CW){1'b0}}, redirect_cnt}, m_cnt);
    chk("trap", {31'd0, trap}, {31'd0, m_trap});
    chk("trap_epc", trap_epc, m_epc);
  endtask

  task automatic model_reset();
    m_boot = 1'b1;
    m_bub  = 0;
    m_pc   = RP;
    m_cnt  = 0;
    m_trap = 1'b0;
    m_epc  = 32'd0;
  endtask

  // one clock: comb checks mid-cycle, model update at the edge, reg checks after
  task automatic step();
    bit          r;
    logic [31:0] t;
    #2;
    r = m_redir();
    t = m_tgt();
    chk("if_id_flush", {31'd0, if_id_flush}, {31'd0, r});
    chk("id_ex_flush", {31'd0, id_ex_flush}, {31'd0, r});
    if (m_run()) chk("npc_op", {27'd0, npc_op}, {27'd0, m_op()});
    @(posedge clk);
    m_trap = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_bub > 0) begin
      m_bub--;
    end else if (r) begin
      m_pc = t;
`ifdef PC_MISALIGN_TRAP_EN
      if (t[1:0] != 2'b00) begin
        m_pc   = TV;
        m_trap = 1'b1;
        m_epc  = ex_pc;
      end
`endif
      if (m_cnt < (1 << CW) - 1) m_cnt++;
      m_bub = FC;
    end else if (!stall && if_ready) begin
      m_pc = m_pc + 32'd4;
    end
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    model_reset();
    check_regs();
    chk("rst_flush", {31'd0, if_id_flush | id_ex_flush}, 32'd0);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    idle();
    rstn = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // boot then sequential fetch
    chk("t1_pc0", pc, 32'h0);
    chk("t1_valid0", {31'd0, pc_valid}, 32'd0);
    step();
    chk("t1_pc_run", pc, 32'h0);
    step();
    chk("t1_pc4", pc, 32'h4);
    step();
    chk("t1_pc8", pc, 32'h8);
    for (int i = 0; i < 6; i++) step();
    chk("t2_pc20", pc, 32'h20);

    // taken branch
    ex_valid = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1;
    ex_pc = 32'h18; ex_imm = 32'h40;
    #1;
    chk("t2_npc_op", {27'd0, npc_op}, {27'd0, NPC_BRANCH});
    chk("t2_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd3);
    step();
    chk("t2_pc58", pc, 32'h58);
    chk("t2_bubble", {31'd0, pc_valid}, 32'd0);
    chk("t2_cnt", {{(32-CW){1'b0}}, redirect_cnt}, 32'd1);
    idle();
    step();
    chk("t2_valid", {31'd0, pc_valid}, 32'd1);

    // JALR under stall
    ex_valid = 1'b1; ex_jalr = 1'b1; alu_out = 32'h105; stall = 1'b1;
    step();
    chk("t3_pc104", pc, 32'h104);
    idle();
    step();

    // land at 0x40, then stall three cycles
    ex_valid = 1'b1; ex_jal = 1'b1; ex_pc = 32'h0; ex_imm = 32'h40;
    step();
    idle();
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("t4_hold", pc, 32'h40);
    stall = 1'b0;
    step();
    chk("t4_pc44", pc, 32'h44);

    // JAL arriving during FLUSH is dropped
    ex_valid = 1'b1; ex_jal = 1'b1; ex_pc = 32'h44; ex_imm = 32'h80;
    step();
    ex_pc = 32'h200; ex_imm = 32'h1000;
    step();
    chk("t5_pc", pc, 32'hC4);
    chk("t5_cnt", {{(32-CW){1'b0}}, redirect_cnt}, 32'd4);
    idle();
    step();

    // misaligned JAL target
    ex_valid = 1'b1; ex_jal = 1'b1; ex_pc = 32'h10; ex_imm = 32'h6;
    step();
`ifdef PC_MISALIGN_TRAP_EN
    chk("t6_pc", pc, TV);
    chk("t6_trap", {31'd0, trap}, 32'd1);
    chk("t6_epc", trap_epc, 32'h10);
`else
    chk("t6_pc", pc, 32'h16);
    chk("t6_trap", {31'd0, trap}, 32'd0);
`endif
    idle();
    step();
    chk("t6_trap_pulse", {31'd0, trap}, 32'd0);

    // address wrap
    ex_valid = 1'b1; ex_jalr = 1'b1; alu_out = 32'hFFFF_FFF9;
    step();
    idle();
    for (int i = 0; i < 3; i++) step();
    chk("wrap_pc", pc, 32'h0);

    // async reset in the middle of FLUSH
    ex_valid = 1'b1; ex_jal = 1'b1; ex_pc = 32'h30; ex_imm = 32'h8;
    step();
    idle();
    #2;
    do_reset();
    chk("mid_rst_pc", pc, RP);
    chk("mid_rst_valid", {31'd0, pc_valid}, 32'd0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      stall     = ($urandom_range(0, 9) < 2);
      if_ready  = ($urandom_range(0, 9) < 8);
      ex_valid  = ($urandom_range(0, 9) < 7);
      ex_branch = $urandom_range(0, 2) == 0;
      ex_taken  = $urandom_range(0, 1) == 1;
      ex_jal    = $urandom_range(0, 5) == 0;
      ex_jalr   = $urandom_range(0, 5) == 0;
      ex_pc     = $urandom & 32'hFFFF_FFFC;
      ex_imm    = $urandom_range(0, 3) == 0 ? $urandom : $urandom & 32'h0000_0FFC;
      alu_out   = $urandom_range(0, 7) == 0 ? 32'hFFFF_FFF4 : $urandom;
      if ($urandom_range(0, 99) == 0) begin
        #2;
        do_reset();
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
